// File: rtl/enigma_pkg.sv
// enigma_pkg: shared constants and types for the enigma datapath.
//   CODE_W / DEPTH  symbol width and table size (DEPTH == 2**CODE_W)
//   TBL_*           table_idx values selecting which block a load targets
//   shift_amt_t     per-cycle rotation amount handed from rotor B to rotor A
package enigma_pkg;
  localparam int CODE_W = 6;
  localparam int DEPTH  = 64;

  localparam logic [1:0] TBL_ROTOR_A = 2'd0;
  localparam logic [1:0] TBL_ROTOR_B = 2'd1;
  localparam logic [1:0] TBL_PLUG    = 2'd2;
  localparam logic [1:0] TBL_REFL    = 2'd3;

  typedef logic [1:0] shift_amt_t;
endpackage

// File: rtl/rotor_a_stage_if.sv
// rotor_a_stage_if: load/encrypt bus of rotor A.
//   master : drives load, table_idx, code_in, encrypt, rotorB_backward_out,
//            rotorA_shift_amount; observes the outputs
//   slave  : the rotor itself
//   dup_err exists only when ROTOR_A_DUP_CHECK_EN is defined.
interface rotor_a_stage_if #(parameter int CODE_W = enigma_pkg::CODE_W);
  import enigma_pkg::shift_amt_t;

  logic              load;
  logic [1:0]        table_idx;
  logic [CODE_W-1:0] code_in;
  logic              encrypt;
  logic [CODE_W-1:0] rotorB_backward_out;
  shift_amt_t        rotorA_shift_amount;
  logic [CODE_W-1:0] rotorA_forward_out;
  logic [CODE_W-1:0] rotorA_backward_out;
  logic              load_done;
`ifdef ROTOR_A_DUP_CHECK_EN
  logic              dup_err;

  modport master (output load, table_idx, code_in, encrypt, rotorB_backward_out,
                         rotorA_shift_amount,
                  input  rotorA_forward_out, rotorA_backward_out, load_done, dup_err);
  modport slave  (input  load, table_idx, code_in, encrypt, rotorB_backward_out,
                         rotorA_shift_amount,
                  output rotorA_forward_out, rotorA_backward_out, load_done, dup_err);
`else
  modport master (output load, table_idx, code_in, encrypt, rotorB_backward_out,
                         rotorA_shift_amount,
                  input  rotorA_forward_out, rotorA_backward_out, load_done);
  modport slave  (input  load, table_idx, code_in, encrypt, rotorB_backward_out,
                         rotorA_shift_amount,
                  output rotorA_forward_out, rotorA_backward_out, load_done);
`endif
endinterface

// File: rtl/rotor_inv_lookup.sv
// rotor_inv_lookup: combinational inverse table lookup.
//   tbl  in   DEPTH x CODE_W table contents
//   key  in   symbol to search for
//   idx  out  lowest index i with tbl[i]==key; 0 when nothing matches
// Shared by every rotor/plugboard backward path.
module rotor_inv_lookup #(
  parameter int CODE_W = enigma_pkg::CODE_W,
  parameter int DEPTH  = enigma_pkg::DEPTH
) (
  input  logic [DEPTH-1:0][CODE_W-1:0] tbl,
  input  logic [CODE_W-1:0]            key,
  output logic [CODE_W-1:0]            idx
);
  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (tbl[i] == key) idx = CODE_W'(i);
  end
endmodule

// File: rtl/rotor_a_stage.sv
// rotor_a_stage: first rotor of the enigma datapath (feeds rotor B).
//   clk   in  rising-edge clock
//   rst   in  asynchronous reset, active-high
//   bus   slave modport of rotor_a_stage_if:
//         load/table_idx/code_in  table load, one entry per cycle (table_idx==0)
//         encrypt/code_in         forward lookup table[code_in]
//         rotorB_backward_out     backward key, answered with its inverse index
//         rotorA_shift_amount     rotation applied on each encrypt edge
//         load_done               all DEPTH entries written
// Optional: ROTOR_A_DUP_CHECK_EN adds a seen vector and sticky dup_err that
// flags a symbol loaded more than once.
module rotor_a_stage #(
  parameter int CODE_W = enigma_pkg::CODE_W,
  parameter int DEPTH  = enigma_pkg::DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  rotor_a_stage_if.slave  bus
);
  import enigma_pkg::TBL_ROTOR_A;

  localparam logic [CODE_W-1:0] CNT_MAX = CODE_W'(DEPTH-1);

  logic [DEPTH-1:0][CODE_W-1:0] tbl;
  logic [DEPTH-1:0][CODE_W-1:0] rot_tbl;
  logic [CODE_W-1:0]            load_cnt;
  logic                         load_done;
  logic                         load_hit;

  assign load_hit = bus.load && (bus.table_idx == TBL_ROTOR_A);

  // Rotate toward higher indices; the 6-bit subtraction supplies the wrap.
  always_comb begin
    rot_tbl = tbl;
    for (int i = 0; i < DEPTH; i++)
      rot_tbl[i] = tbl[CODE_W'(i) - CODE_W'(bus.rotorA_shift_amount)];
  end

  // A valid load beats encrypt: that cycle writes and does not rotate.
  // load_cnt parks at DEPTH-1 so late loads keep overwriting the last entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl       <= '0;
      load_cnt  <= '0;
      load_done <= 1'b0;
    end else if (load_hit) begin
      tbl[load_cnt] <= bus.code_in;
      if (load_cnt == CNT_MAX) load_done <= 1'b1;
      else                     load_cnt  <= load_cnt + 1'b1;
    end else if (bus.encrypt) begin
      tbl <= rot_tbl;
    end
  end

`ifdef ROTOR_A_DUP_CHECK_EN
  logic [DEPTH-1:0] seen;
  logic             dup_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen    <= '0;
      dup_err <= 1'b0;
    end else if (load_hit) begin
      if (seen[bus.code_in]) dup_err <= 1'b1;
      seen[bus.code_in] <= 1'b1;
    end
  end

  assign bus.dup_err = dup_err;
`endif

  // Both lookups read the pre-rotation table.
  assign bus.rotorA_forward_out = bus.encrypt ? tbl[bus.code_in] : '0;
  assign bus.load_done          = load_done;

  rotor_inv_lookup #(.CODE_W(CODE_W), .DEPTH(DEPTH)) u_inv (
    .tbl (tbl),
    .key (bus.rotorB_backward_out),
    .idx (bus.rotorA_backward_out)
  );
endmodule

// File: tb/tb_rotor_a_stage.sv
// tb_rotor_a_stage: directed + randomized bench for rotor_a_stage against a
// table-level reference model.
module tb_rotor_a_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rotor_a_stage_if ifc ();

  rotor_a_stage dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  int n_cmp = 0;
  int n_err = 0;

  // reference model
  bit [5:0] mtab [64];
  int       mcnt;
  bit       mdone;
  bit [63:0] mseen;
  bit       mdup;

  logic [5:0] last_fwd, last_bwd;
  logic       last_done;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_bwd(input bit [5:0] key);
    for (int i = 0; i < 64; i++) if (mtab[i] == key) return i;
    return 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) mtab[i] = '0;
    mcnt = 0; mdone = 0; mseen = '0; mdup = 0;
  endtask

  // Drive one cycle: check combinational outputs against the model before the
  // edge, then advance the model by the edge's effect.
  task automatic cyc(input bit ld, input bit [1:0] ti, input bit [5:0] code,
                     input bit en, input bit [5:0] bk, input bit [1:0] amt);
    bit [5:0] tmp [64];
    ifc.load = ld; ifc.table_idx = ti; ifc.code_in = code; ifc.encrypt = en;
    ifc.rotorB_backward_out = bk; ifc.rotorA_shift_amount = amt;
    #1;
    last_fwd = ifc.rotorA_forward_out;
    last_bwd = ifc.rotorA_backward_out;
    last_done = ifc.load_done;
    chk("fwd", int'(last_fwd), en ? int'(mtab[code]) : 0);
    chk("bwd", int'(last_bwd), m_bwd(bk));
    chk("load_done", int'(last_done), int'(mdone));
`ifdef ROTOR_A_DUP_CHECK_EN
    chk("dup_err", int'(ifc.dup_err), int'(mdup));
`endif
    @(posedge clk);
    if (ld && ti == 2'd0) begin
      mtab[mcnt] = code;
      if (mcnt == 63) mdone = 1; else mcnt++;
      if (mseen[code]) mdup = 1;
      mseen[code] = 1;
    end else if (en) begin
      tmp = mtab;
      for (int i = 0; i < 64; i++) mtab[i] = tmp[(i - int'(amt) + 64) % 64];
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ifc.load = 0; ifc.table_idx = 0; ifc.code_in = 0; ifc.encrypt = 0;
    ifc.rotorB_backward_out = 0; ifc.rotorA_shift_amount = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic load_identity();
    for (int i = 0; i < 64; i++) cyc(1, 0, 6'(i), 0, 6'(i), 0);
  endtask

  initial begin
    bit [5:0] r6, r6b;
    int sel;
    idle_inputs();
    m_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // reset state
    cyc(0, 0, 9, 1, 0, 1);
    chk("rst_fwd", int'(last_fwd), 0);
    chk("rst_bwd", int'(last_bwd), 0);
    chk("rst_done", int'(last_done), 0);

    // identity load; load_done rises on the 64th edge
    for (int i = 0; i < 63; i++) cyc(1, 0, 6'(i), 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("done_after63", int'(last_done), 0);
    cyc(1, 0, 63, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("done_after64", int'(last_done), 1);

    // identity lookups, amt=0 leaves table as is
    cyc(0, 0, 17, 1, 17, 0);
    chk("id_fwd17", int'(last_fwd), 17);
    chk("id_bwd17", int'(last_bwd), 17);

    // amt=1 rotation
    cyc(0, 0, 5, 1, 9, 1);
    chk("rot1_fwd_now", int'(last_fwd), 5);
    cyc(0, 0, 5, 1, 4, 0);
    chk("rot1_fwd_next", int'(last_fwd), 4);
    chk("rot1_bwd_next", int'(last_bwd), 5);

    // amt=3 x22 -> net shift of 2 with wrap
    do_reset();
    load_identity();
    for (int i = 0; i < 22; i++) cyc(0, 0, 6'(i), 1, 6'(i), 3);
    cyc(0, 0, 0, 1, 62, 0);
    chk("wrap_t0", int'(last_fwd), 62);
    chk("wrap_bwd62", int'(last_bwd), 0);
    cyc(0, 0, 1, 1, 0, 0);
    chk("wrap_t1", int'(last_fwd), 63);
    chk("wrap_bwd0", int'(last_bwd), 2);

    // foreign table_idx ignored; then load beats encrypt
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 2'(1 + (i % 3)), 6'($urandom_range(1, 63)), 0, 0, 0);
    cyc(1, 0, 42, 1, 0, 2);
    cyc(1, 0, 11, 0, 0, 0);
    cyc(0, 0, 0, 1, 11, 0);
    chk("prio_t0", int'(last_fwd), 42);
    chk("prio_bwd11", int'(last_bwd), 1);
    cyc(0, 0, 2, 1, 42, 0);
    chk("prio_t2", int'(last_fwd), 0);
    chk("prio_done", int'(last_done), 0);

    // async reset mid-load at load_cnt=30
    do_reset();
    for (int i = 0; i < 30; i++) cyc(1, 0, 6'(i + 1), 0, 0, 0);
    ifc.load = 1; ifc.table_idx = 0; ifc.code_in = 33; ifc.encrypt = 1;
    ifc.code_in = 5; ifc.rotorB_backward_out = 3;
    #1;
    chk("pre_rst_fwd", int'(ifc.rotorA_forward_out), 6);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_fwd", int'(ifc.rotorA_forward_out), 0);
    chk("mid_rst_bwd", int'(ifc.rotorA_backward_out), 0);
    chk("mid_rst_done", int'(ifc.load_done), 0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    cyc(1, 0, 50, 0, 0, 0);
    cyc(0, 0, 0, 1, 50, 0);
    chk("post_rst_t0", int'(last_fwd), 50);
    chk("post_rst_bwd", int'(last_bwd), 0);

`ifdef ROTOR_A_DUP_CHECK_EN
    do_reset();
    cyc(1, 0, 63, 0, 0, 0);
    cyc(1, 0, 7, 0, 0, 0);
    cyc(1, 0, 63, 0, 0, 0);
    #0;
    chk("dup_before", int'(mdup), 1);
    cyc(0, 0, 3, 1, 0, 1);
    cyc(0, 0, 3, 1, 0, 2);
    chk("dup_hold", int'(ifc.dup_err), 1);
    do_reset();
    #1;
    chk("dup_cleared", int'(ifc.dup_err), 0);
`endif

    // randomized: random table, then mixed traffic
    do_reset();
    for (int i = 0; i < 64; i++) cyc(1, 0, 6'($urandom), $urandom_range(0, 1), 6'($urandom), 2'($urandom));
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      r6  = 6'($urandom);
      r6b = ($urandom_range(0, 1) == 1) ? mtab[$urandom_range(0, 63)] : 6'($urandom);
      case (sel)
        0:       cyc(1, 0, r6, $urandom_range(0, 1), r6b, 2'($urandom));
        1:       cyc(1, 2'($urandom_range(1, 3)), r6, $urandom_range(0, 1), r6b, 2'($urandom));
        2:       cyc(0, 2'($urandom), r6, 0, r6b, 2'($urandom));
        default: cyc(0, 2'($urandom), r6, 1, r6b, 2'($urandom));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
